// File: rtl/result_checker.sv
// result_checker: scoreboard for an arithmetic controller. Each issued operation
// pushes its expected result into a small FIFO; each returned result pops the
// head and is compared, updating saturating pass/fail counters.
// Optional build macro CHK_TIMEOUT_EN adds a watchdog on the FIFO head wait time.
module result_checker #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     issue_valid,
  input  logic                     issue_type,
  input  logic signed [7:0]        x1,
  input  logic signed [7:0]        x2,
  input  logic signed [7:0]        v,
  input  logic signed [7:0]        t,
  input  logic signed [7:0]        c,
  input  logic signed [15:0]       out,
  input  logic                     op_valid,
  input  logic                     op_type,
  output logic                     issue_ready,
  output logic [15:0]              pass_count,
  output logic [15:0]              fail_count,
  output logic                     mismatch,
  output logic                     error,
  output logic                     timeout,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [16:0]     mem [DEPTH];
  logic [16:0]     head;
  logic            in_run, full, empty, flush;
  logic            do_push, do_pop, overflow;
  logic            res_pass, res_fail, pop_fail;
  logic            to_hit;

  // Expected controller result: 16-bit product, or v*t + c wrapped mod 2^16.
  function automatic logic signed [15:0] calc_expected(
    input logic              typ,
    input logic signed [7:0] a,
    input logic signed [7:0] b,
    input logic signed [7:0] m,
    input logic signed [7:0] n,
    input logic signed [7:0] k
  );
    logic signed [15:0] a16, b16, m16, n16, k16;
    a16 = {{8{a[7]}}, a};
    b16 = {{8{b[7]}}, b};
    m16 = {{8{m[7]}}, m};
    n16 = {{8{n[7]}}, n};
    k16 = {{8{k[7]}}, k};
    calc_expected = typ ? (m16 * n16 + k16) : (a16 * b16);
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] val);
    sat_inc = (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  assign in_run      = (state == RUN);
  assign full        = (count == (AW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign flush       = in_run && !enable;
  assign do_push     = in_run && issue_valid && !full;
  assign overflow    = in_run && issue_valid && full;
  assign do_pop      = in_run && op_valid && !empty;
  assign head        = mem[rd_ptr];
  assign res_pass    = do_pop && (head[15:0] == out) && (head[16] == op_type);
  // A result with nothing outstanding is a fail too, but does not pop.
  assign res_fail    = in_run && op_valid && !res_pass;
  assign pop_fail    = do_pop && !res_pass;
  assign issue_ready = in_run && !full;
  assign outstanding = count;

`ifdef CHK_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wait_cnt;

  assign to_hit = in_run && enable && !empty && !do_pop && (wait_cnt == WW'(TIMEOUT - 1));

  // Watchdog: count cycles the head has waited; latch timeout when it expires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (!in_run || empty || do_pop) wait_cnt <= '0;
      else                            wait_cnt <= wait_cnt + 1'b1;
      if (to_hit) timeout <= 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; HALT is left only through reset.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN: begin
        if (!enable)     state_nxt = IDLE;
        else if (to_hit) state_nxt = HALT;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO pointers and occupancy; leaving RUN discards everything pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: {type, expected result}.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {issue_type, calc_expected(issue_type, x1, x2, v, t, c)};
  end

  // Result bookkeeping: counters, one-cycle mismatch pulse, sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_count <= '0;
      fail_count <= '0;
      mismatch   <= 1'b0;
      error      <= 1'b0;
    end else begin
      mismatch <= res_fail;
      if (res_pass) pass_count <= sat_inc(pass_count);
      if (res_fail) fail_count <= sat_inc(fail_count);
      if (pop_fail || overflow || to_hit) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker with a queue-based scoreboard of expected
// results; the timeout section follows the CHK_TIMEOUT_EN build macro.
module tb_result_checker;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable, issue_valid, issue_type, op_valid, op_type;
  logic signed [7:0]  x1, x2, v, t, c;
  logic signed [15:0] out;
  logic               issue_ready, mismatch, error, timeout;
  logic [15:0]        pass_count, fail_count;
  logic [$clog2(DEPTH):0] outstanding;

  typedef struct packed {logic typ; logic [15:0] val;} exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_state;            // 0 IDLE, 1 RUN, 2 HALT
  int   m_pass, m_fail;
  logic m_err, m_mis, m_to;

  result_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .issue_valid(issue_valid), .issue_type(issue_type),
    .x1(x1), .x2(x2), .v(v), .t(t), .c(c),
    .out(out), .op_valid(op_valid), .op_type(op_type),
    .issue_ready(issue_ready), .pass_count(pass_count), .fail_count(fail_count),
    .mismatch(mismatch), .error(error), .timeout(timeout), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_result(input logic typ, input int a, b, m, n, k);
    int r;
    r = typ ? (m * n + k) : (a * b);
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pass_count"},  32'(pass_count),  32'(m_pass));
    chk({tag, ".fail_count"},  32'(fail_count),  32'(m_fail));
    chk({tag, ".outstanding"}, 32'(outstanding), 32'(sb.size()));
    chk({tag, ".issue_ready"}, 32'(issue_ready), 32'(m_state == 1 && sb.size() < DEPTH));
    chk({tag, ".mismatch"},    32'(mismatch),    32'(m_mis));
    chk({tag, ".error"},       32'(error),       32'(m_err));
    chk({tag, ".timeout"},     32'(timeout),     32'(m_to));
  endtask

  // One clock of stimulus; the scoreboard is updated as the inputs are driven.
  task automatic step(input logic iv, input logic it, input int a, b, m, n, k,
                      input logic ov, input int o, input logic ot);
    int   n0;
    exp_t h;
    issue_valid = iv; issue_type = it;
    x1 = 8'(a); x2 = 8'(b); v = 8'(m); t = 8'(n); c = 8'(k);
    op_valid = ov; out = 16'(o); op_type = ot;
    m_mis = 1'b0;
    if (m_state == 1 && !enable) begin
      sb.delete();
      m_state = 0;
    end else if (m_state == 1) begin
      n0 = sb.size();
      if (ov) begin
        if (n0 == 0) begin
          m_fail++; m_mis = 1'b1;
        end else begin
          h = sb.pop_front();
          if (h.val === out && h.typ === ot) m_pass++;
          else begin m_fail++; m_mis = 1'b1; m_err = 1'b1; end
        end
      end
      if (iv) begin
        if (n0 == DEPTH) m_err = 1'b1;
        else sb.push_back(exp_t'{typ: it, val: ref_result(it, x1, x2, v, t, c)});
      end
    end else if (m_state == 0 && enable) begin
      m_state = 1;
    end
    @(posedge clk); #1;
    issue_valid = 1'b0; op_valid = 1'b0;
  endtask

  task automatic idle();                        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic issue0(input int a, b);        step(1, 0, a, b, 0, 0, 0, 0, 0, 0); endtask
  task automatic issue1(input int m, n, k);     step(1, 1, 0, 0, m, n, k, 0, 0, 0); endtask
  task automatic res(input int o, input logic ot); step(0, 0, 0, 0, 0, 0, 0, 1, o, ot); endtask

  // Asynchronous reset pulse placed between clock edges, checked while held.
  task automatic do_reset(input string tag);
    enable = 1'b0;
    reset  = 1'b1;
    sb.delete();
    m_state = 0; m_pass = 0; m_fail = 0;
    m_err = 1'b0; m_mis = 1'b0; m_to = 1'b0;
    #2;
    check_all(tag);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t h;
    enable = 0; issue_valid = 0; issue_type = 0; op_valid = 0; op_type = 0;
    x1 = 0; x2 = 0; v = 0; t = 0; c = 0; out = 0;
    #1;
    do_reset("reset0");

    enable = 1'b1;
    idle();
    check_all("enter_run");

    issue0(10, 2);
    res(20, 1'b0);
    check_all("mul_pass");

    issue1(8, 3, -2);
    res(22, 1'b1);
    check_all("mac_pass");
    issue1(8, 3, -2);
    res(23, 1'b1);
    check_all("mac_fail");
    idle();
    check_all("mismatch_drop");

    issue0(5, 5);
    issue0(-3, 7);
    check_all("pend2");
    do_reset("reset_mid");

    enable = 1'b1;
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      if (i % 2 == 0) issue0($urandom_range(0, 255), $urandom_range(0, 255));
      else            issue1($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    end
    check_all("fifo_full");
    issue0(1, 1);
    check_all("overflow");

    for (int i = 0; i < DEPTH; i++) begin
      h = sb[0];
      if (i == 2) res(int'(h.val ^ 16'h0001), h.typ);
      else        res(int'(h.val), h.typ);
      check_all("drain");
    end

    res(0, 1'b0);
    check_all("empty_op");
    step(1, 0, -7, 9, 0, 0, 0, 1, -63, 1'b0);
    check_all("empty_op_with_push");
    issue1(-128, -128, 127);
    check_all("pend2_again");
    h = sb[0];
    step(1, 0, 127, -128, 0, 0, 0, 1, int'(h.val), h.typ);
    check_all("push_pop");

    issue0(3, 3);
    check_all("pend3");
    enable = 1'b0;
    idle();
    check_all("enable_drop");
    step(1, 0, 2, 2, 0, 0, 0, 1, 4, 1'b0);
    check_all("idle_ignore");

    enable = 1'b1;
    idle();
    check_all("rerun");
`ifdef CHK_TIMEOUT_EN
    issue0(4, 4);
    repeat (TIMEOUT - 1) idle();
    check_all("pre_timeout");
    idle();
    m_to = 1'b1; m_err = 1'b1; m_state = 2;
    check_all("timeout");
    h = sb[0];
    step(1, 0, 1, 1, 0, 0, 0, 1, int'(h.val), h.typ);
    check_all("halt_ignore");
`else
    issue0(4, 4);
    repeat (TIMEOUT + 4) idle();
    check_all("no_watchdog");
    h = sb[0];
    res(int'(h.val), h.typ);
    check_all("late_result");
`endif
    do_reset("reset_end");
    idle();
    check_all("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the expected-result FIFO depth as a power of two of at least 2.
REQ-002 SHALL have parameter TIMEOUT, default 16, giving the maximum cycles the FIFO head may wait for its result.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on posedge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, normal-mode gate driven from the BIST enable_normal.
REQ-006 SHALL have port issue_valid, input, 1, marking that the operands are being sent to the controller this cycle.
REQ-007 SHALL have port issue_type, input, 1, giving the issued operation: 0 = x1*x2, 1 = v*t+c.
REQ-008 SHALL have ports x1, x2, v, t, c, input, 8 each, signed operands.
REQ-009 SHALL have ports out (input, 16, signed controller result), op_valid (input, 1) and op_type (input, 1).
REQ-010 SHALL have port issue_ready, output, 1, high when the FIFO is not full and the state is RUN.
REQ-011 SHALL have ports pass_count and fail_count, output, 16 each, saturating at 16'hFFFF.
REQ-012 SHALL have ports mismatch (output, 1, one-cycle pulse), error (output, 1, sticky) and timeout (output, 1, sticky).
REQ-013 SHALL have port outstanding, output, $clog2(DEPTH)+1 bits, giving the FIFO occupancy.

Function
REQ-014 SHALL have states IDLE, RUN and HALT.
REQ-015 IDLE SHALL go to RUN when enable=1; RUN SHALL go to IDLE when enable=0, flushing the FIFO; RUN SHALL go to HALT on timeout; HALT SHALL exit only on reset.
REQ-016 In RUN, when issue_valid=1 and the FIFO is not full, the block SHALL push {issue_type, expected}.
- expected for type 0 = x1*x2 as a 16-bit signed product.
- expected for type 1 = v*t + sign-extended c, truncated mod 2^16.
REQ-017 In RUN, when issue_valid=1 and the FIFO is full, the block SHALL drop the issue and set error (overflow).
REQ-018 In RUN, when op_valid=1 and the FIFO is non-empty, the block SHALL pop the head and compare.
- Pass: out equals the stored expected AND op_type equals the stored type; pass_count increments.
- Otherwise: fail_count increments, mismatch pulses and error is set.
REQ-019 When op_valid=1 with an empty FIFO, the block SHALL count a fail and pulse mismatch, and SHALL NOT pop.
- This applies even if an issue is pushed in the same cycle.
REQ-020 A simultaneous push and pop SHALL both take effect, leaving outstanding unchanged.
REQ-021 The counters and mismatch SHALL update in the cycle after op_valid is sampled (latency 1).
REQ-022 In IDLE and HALT, the block SHALL ignore issue_valid and op_valid, and SHALL hold the counters, error and timeout.
REQ-023 The FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-024 When reset=1, the block SHALL asynchronously enter IDLE and empty the FIFO.
- pass_count=0, fail_count=0, outstanding=0.
- mismatch=0, error=0, timeout=0, issue_ready=0.
REQ-025 A reset mid-operation SHALL discard all pending expected results without counting them.

Configuration
REQ-026 With macro CHK_TIMEOUT_EN defined, the block SHALL run the timeout watchdog.
- A wait counter clears on every pop and whenever the FIFO is empty.
- Otherwise the counter increments each RUN cycle.
- On reaching TIMEOUT, timeout and error are set and the state goes to HALT.
REQ-027 Without CHK_TIMEOUT_EN, the block SHALL contain no watchdog logic, timeout SHALL be tied to 0, and HALT SHALL be unreachable.

Verification
REQ-028 The bench SHALL cover: enable=1; issue type 0 with x1=10, x2=2; op_valid with out=20, op_type=0 one cycle later -> pass_count=1, error=0.
REQ-029 The bench SHALL cover: issue type 1 with v=8, t=3, c=-2; result out=22 -> pass; same issue with out=23 -> fail_count=1, mismatch pulses for 1 cycle, error=1.
REQ-030 The bench SHALL cover: 4 issues with no results -> outstanding=4 and issue_ready=0; a 5th issue -> dropped, error=1, outstanding stays 4.
REQ-031 The bench SHALL cover: op_valid with an empty FIFO -> fail_count increments and outstanding stays 0; simultaneous push+pop at outstanding=2 -> outstanding remains 2.
REQ-032 The bench SHALL cover (CHK_TIMEOUT_EN, TIMEOUT=16): one issue and no result for 16 cycles -> timeout=1, HALT, later op_valid ignored; reset -> all outputs 0 and IDLE.
REQ-033 The bench SHALL cover: enable dropped with outstanding=3 -> IDLE, outstanding=0, counters held.
